// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-to-device memory interconnect: FSM states,
// error read data and the default SoC memory map.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR_RESP
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [31:0] BRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] BRAM_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] LEDS_BASE  = 32'h4000_0000;
    localparam logic [31:0] LEDS_MASK  = 32'hFFFF_FF00;
    localparam logic [31:0] SDRAM_BASE = 32'h2000_0000;
    localparam logic [31:0] SDRAM_MASK = 32'hF000_0000;

    localparam int unsigned DEFAULT_N = 3;

    // Device 0 sits in the least significant 32 bits.
    localparam logic [DEFAULT_N*32-1:0] DEFAULT_DEV_BASE = {SDRAM_BASE, LEDS_BASE, BRAM_BASE};
    localparam logic [DEFAULT_N*32-1:0] DEFAULT_DEV_MASK = {SDRAM_MASK, LEDS_MASK, BRAM_MASK};

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_match.sv
// Combinational address decoder: reports whether any device window matches
// and the lowest-index matching device.
module mem_addr_match
    import mem_bus_pkg::*;
#(
    parameter int unsigned          N        = DEFAULT_N,
    parameter logic [N*32-1:0]      DEV_BASE = DEFAULT_DEV_BASE,
    parameter logic [N*32-1:0]      DEV_MASK = DEFAULT_DEV_MASK,
    localparam int unsigned         SEL_W    = sel_width(N)
) (
    input  logic [31:0]      addr,
    output logic             found,
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && ((addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32])) begin
                found = 1'b1;
                sel   = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_interconnect.sv
// PicoRV32 native-port interconnect: registered one-shot decode, single-device
// handshake forwarding, unmapped/timeout error responses and error status.
module mem_interconnect
    import mem_bus_pkg::*;
#(
    parameter int unsigned     N         = DEFAULT_N,
    parameter logic [N*32-1:0] DEV_BASE  = DEFAULT_DEV_BASE,
    parameter logic [N*32-1:0] DEV_MASK  = DEFAULT_DEV_MASK,
    parameter int unsigned     TIMEOUT   = 1024,
    parameter logic [31:0]     ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            cpu_mem_valid,
    input  logic [31:0]     cpu_mem_addr,
    output logic            cpu_mem_ready,
    output logic [31:0]     cpu_mem_rdata,
    output logic [N-1:0]    dev_mem_valid,
    input  logic [N-1:0]    dev_mem_ready,
    input  logic [N*32-1:0] dev_mem_rdata,
    output logic            bus_error,
    output logic [15:0]     err_count,
    output logic [31:0]     err_addr,
    output logic            err_timeout
);

    localparam int unsigned      SEL_W   = sel_width(N);
    localparam int unsigned      WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              found;
    logic [SEL_W-1:0]  match_sel;
    logic [SEL_W-1:0]  sel;
    logic [31:0]       addr_q;
    logic [WD_W-1:0]   wd;
    logic              wd_expired;
    logic              sel_ready;
    logic [31:0]       sel_rdata;

    mem_addr_match #(
        .N        (N),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_match (
        .addr  (cpu_mem_addr),
        .found (found),
        .sel   (match_sel)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SEL_W'(i) == sel) begin
                sel_ready = dev_mem_ready[i];
                sel_rdata = dev_mem_rdata[32*i +: 32];
            end
        end
    end

    assign wd_expired = (wd == WD_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Device ready takes priority over watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cpu_mem_valid) begin
                    state_next = found ? BUSY : ERR_RESP;
                end
            end
            BUSY: begin
                if (!cpu_mem_valid || sel_ready) begin
                    state_next = IDLE;
                end else if (wd_expired) begin
                    state_next = ERR_RESP;
                end
            end
            ERR_RESP: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        dev_mem_valid = '0;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
        bus_error     = 1'b0;
        unique case (state)
            BUSY: begin
                for (int unsigned i = 0; i < N; i++) begin
                    dev_mem_valid[i] = cpu_mem_valid && (SEL_W'(i) == sel);
                end
                cpu_mem_ready = sel_ready;
                cpu_mem_rdata = sel_rdata;
            end
            ERR_RESP: begin
                cpu_mem_ready = 1'b1;
                cpu_mem_rdata = ERR_RDATA;
                bus_error     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sel         <= '0;
            addr_q      <= '0;
            wd          <= '0;
            err_count   <= '0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE && cpu_mem_valid) begin
                sel    <= match_sel;
                addr_q <= cpu_mem_addr;
            end
            wd <= (state == BUSY) ? wd + 1'b1 : '0;
            if (state != ERR_RESP && state_next == ERR_RESP) begin
                err_timeout <= (state == BUSY);
            end
            if (state == ERR_RESP) begin
                err_addr <= addr_q;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    a_valid_onehot: assert property (@(posedge clk) disable iff (!nrst) $onehot0(dev_mem_valid));
    a_error_completes: assert property (@(posedge clk) disable iff (!nrst) bus_error |-> cpu_mem_ready);

endmodule

// File: tb/tb_mem_interconnect.sv
// Self-checking bench for mem_interconnect: directed corner cases plus
// randomized transactions against a memory-map reference model.
module tb_mem_interconnect;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    // Device 3 overlaps BRAM so lowest-index priority is observable.
    localparam logic [N*32-1:0] TB_BASE = {32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] TB_MASK = {32'hFFFF_F000, 32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_0000};

    int unsigned m_base [N] = '{32'h0000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
    int unsigned m_mask [N] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hF000_0000, 32'hFFFF_F000};

    logic            clk = 1'b0;
    logic            nrst;
    logic            cpu_mem_valid;
    logic [31:0]     cpu_mem_addr;
    logic            cpu_mem_ready;
    logic [31:0]     cpu_mem_rdata;
    logic [N-1:0]    dev_mem_valid;
    logic [N-1:0]    dev_mem_ready;
    logic [N*32-1:0] dev_mem_rdata;
    logic            bus_error;
    logic [15:0]     err_count;
    logic [31:0]     err_addr;
    logic            err_timeout;

    int checks   = 0;
    int failures = 0;

    logic [15:0]  m_err_count;
    logic [31:0]  m_err_addr;
    logic         m_err_timeout;
    logic [N-1:0] vlog[$];

    mem_interconnect #(
        .N         (N),
        .DEV_BASE  (TB_BASE),
        .DEV_MASK  (TB_MASK),
        .TIMEOUT   (TIMEOUT),
        .ERR_RDATA (ERRD)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_ready (cpu_mem_ready),
        .cpu_mem_rdata (cpu_mem_rdata),
        .dev_mem_valid (dev_mem_valid),
        .dev_mem_ready (dev_mem_ready),
        .dev_mem_rdata (dev_mem_rdata),
        .bus_error     (bus_error),
        .err_count     (err_count),
        .err_addr      (err_addr),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_valid(input int idx, input int erc, input bit eerr, input int c);
        if (idx < 0) return '0;
        if (eerr && c == erc) return '0;
        return N'(1) << idx;
    endfunction

    task automatic model_txn(input logic [31:0] a, input int idx, input int lat,
                             output int erc, output bit eerr);
        if (idx < 0) erc = 1;
        else if (lat >= 0 && lat + 1 <= TIMEOUT) erc = lat + 1;
        else erc = TIMEOUT + 1;
        eerr = (idx < 0) || (erc == TIMEOUT + 1);
        if (eerr) begin
            if (m_err_count != 16'hFFFF) m_err_count = m_err_count + 16'd1;
            m_err_addr    = a;
            m_err_timeout = (idx >= 0);
        end
    endtask

    // Acts as CPU and as device tgt (ready after lat wait cycles, -1 = never);
    // non-target devices raise random ready noise. Returns the completion cycle.
    task automatic do_txn(input logic [31:0] addr, input int tgt, input int lat, input logic [31:0] drd,
                          output int rc, output logic [31:0] rrd, output logic rerr);
        logic [N-1:0] rdy;
        vlog.delete();
        rc = -1; rrd = '0; rerr = 1'b0;
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = addr;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            @(posedge clk); #1;
            cpu_mem_addr = $urandom;
            for (int i = 0; i < N; i++) dev_mem_rdata[32*i +: 32] = $urandom;
            rdy = N'($urandom);
            if (tgt >= 0) begin
                rdy[tgt] = 1'b0;
                if (lat >= 0 && c == lat + 1) begin
                    rdy[tgt] = 1'b1;
                    dev_mem_rdata[32*tgt +: 32] = drd;
                end
            end
            dev_mem_ready = rdy;
            @(negedge clk);
            vlog.push_back(dev_mem_valid);
            if (cpu_mem_ready) begin
                rc = c; rrd = cpu_mem_rdata; rerr = bus_error;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_mem_valid = 1'b0;
        dev_mem_ready = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0; cpu_mem_valid = 1'b0; cpu_mem_addr = '0; dev_mem_ready = '0; dev_mem_rdata = '0;
        m_err_count = '0; m_err_addr = '0; m_err_timeout = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checks++; if (cpu_mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", cpu_mem_ready); end
        checks++; if (cpu_mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", cpu_mem_rdata); end
        checks++; if (dev_mem_valid !== '0) begin failures++; $display("FAIL reset_dev_valid: got %b want 0", dev_mem_valid); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count: got %h want 0", err_count); end
        checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
    endtask

    task automatic test_bram_read();
        int rc; logic [31:0] rrd; logic rerr;
        do_txn(32'h0000_0010, 0, 0, 32'h1234_5678, rc, rrd, rerr);
        checks++; if (rc != 1) begin failures++; $display("FAIL bram_latency: got %0d want 1", rc); end
        checks++; if (rrd !== 32'h1234_5678) begin failures++; $display("FAIL bram_rdata: got %h want 12345678", rrd); end
        checks++; if (rerr !== 1'b0) begin failures++; $display("FAIL bram_error: got %b want 0", rerr); end
        checks++; if (vlog[0] !== 4'b0001) begin failures++; $display("FAIL bram_dev_valid: got %b want 0001", vlog[0]); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL bram_err_count: got %h want 0", err_count); end
    endtask

    task automatic test_unmapped();
        int rc; logic [31:0] rrd; logic rerr;
        do_txn(32'h3000_0000, -1, 0, 32'h0, rc, rrd, rerr);
        m_err_count = 16'd1; m_err_addr = 32'h3000_0000; m_err_timeout = 1'b0;
        checks++; if (rc != 1) begin failures++; $display("FAIL unmapped_latency: got %0d want 1", rc); end
        checks++; if (rrd !== ERRD) begin failures++; $display("FAIL unmapped_rdata: got %h want %h", rrd, ERRD); end
        checks++; if (rerr !== 1'b1) begin failures++; $display("FAIL unmapped_bus_error: got %b want 1", rerr); end
        checks++; if (vlog[0] !== '0) begin failures++; $display("FAIL unmapped_dev_valid: got %b want 0", vlog[0]); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL unmapped_error_pulse: got %b want 0 after response", bus_error); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL unmapped_err_count: got %h want 1", err_count); end
        checks++; if (err_addr !== 32'h3000_0000) begin failures++; $display("FAIL unmapped_err_addr: got %h want 30000000", err_addr); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL unmapped_err_timeout: got %b want 0", err_timeout); end
    endtask

    task automatic test_timeout();
        int rc; logic [31:0] rrd; logic rerr; int bad;
        do_txn(32'h2000_0004, 2, -1, 32'h0, rc, rrd, rerr);
        m_err_count = 16'd2; m_err_addr = 32'h2000_0004; m_err_timeout = 1'b1;
        checks++; if (rc != TIMEOUT + 1) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", rc, TIMEOUT + 1); end
        checks++; if (rrd !== ERRD) begin failures++; $display("FAIL timeout_rdata: got %h want %h", rrd, ERRD); end
        checks++; if (rerr !== 1'b1) begin failures++; $display("FAIL timeout_bus_error: got %b want 1", rerr); end
        bad = -1;
        if (vlog.size() != TIMEOUT + 1) bad = 0;
        else foreach (vlog[k]) if (bad < 0 && vlog[k] !== ((k < TIMEOUT) ? 4'b0100 : 4'b0000)) bad = k + 1;
        checks++; if (bad >= 0) begin failures++; $display("FAIL timeout_dev_valid: trace wrong at cycle %0d (len got %0d want %0d)", bad, vlog.size(), TIMEOUT + 1); end
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_err_timeout: got %b want 1", err_timeout); end
        checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL timeout_err_count: got %h want 2", err_count); end
        checks++; if (err_addr !== 32'h2000_0004) begin failures++; $display("FAIL timeout_err_addr: got %h want 20000004", err_addr); end
    endtask

    task automatic test_ready_at_expiry();
        int rc; logic [31:0] rrd; logic rerr; logic [31:0] drd;
        drd = $urandom;
        do_txn(32'h2000_0004, 2, TIMEOUT - 1, drd, rc, rrd, rerr);
        checks++; if (rc != TIMEOUT) begin failures++; $display("FAIL expiry_latency: got %0d want %0d", rc, TIMEOUT); end
        checks++; if (rrd !== drd) begin failures++; $display("FAIL expiry_rdata: got %h want %h", rrd, drd); end
        checks++; if (rerr !== 1'b0) begin failures++; $display("FAIL expiry_bus_error: got %b want 0", rerr); end
        checks++; if (err_count !== m_err_count) begin failures++; $display("FAIL expiry_err_count: got %h want %h", err_count, m_err_count); end
    endtask

    task automatic test_overlap_back_to_back();
        int rc; logic [31:0] rrd; logic rerr; logic [31:0] drd;
        drd = $urandom;
        do_txn(32'h0000_0100, 0, 1, drd, rc, rrd, rerr);
        checks++; if (vlog[0] !== 4'b0001) begin failures++; $display("FAIL overlap_select: got %b want 0001", vlog[0]); end
        checks++; if (rc != 2 || rrd !== drd) begin failures++; $display("FAIL overlap_complete: got cycle %0d data %h want 2 %h", rc, rrd, drd); end
        drd = $urandom;
        do_txn(32'h4000_0004, 1, 0, drd, rc, rrd, rerr);
        checks++; if (vlog[0] !== 4'b0010) begin failures++; $display("FAIL b2b_led_valid: got %b want 0010", vlog[0]); end
        checks++; if (rc != 1 || rrd !== drd || rerr !== 1'b0) begin failures++; $display("FAIL b2b_led_complete: got cycle %0d data %h err %b want 1 %h 0", rc, rrd, rerr, drd); end
    endtask

    task automatic test_abort();
        int rc; logic [31:0] rrd; logic rerr; logic saw; logic [31:0] drd;
        @(negedge clk);
        cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h2000_0008; dev_mem_ready = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dev_mem_valid !== 4'b0100) begin failures++; $display("FAIL abort_busy_valid: got %b want 0100", dev_mem_valid); end
        cpu_mem_valid = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            @(negedge clk);
            if (bus_error || cpu_mem_ready || dev_mem_valid != '0) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_quiet: got activity %b want 0", saw); end
        checks++; if (err_count !== m_err_count) begin failures++; $display("FAIL abort_err_count: got %h want %h", err_count, m_err_count); end
        drd = $urandom;
        do_txn(32'h0000_0040, 0, 2, drd, rc, rrd, rerr);
        checks++; if (rc != 3 || rrd !== drd || rerr !== 1'b0) begin failures++; $display("FAIL abort_next_txn: got cycle %0d data %h err %b want 3 %h 0", rc, rrd, rerr, drd); end
    endtask

    task automatic test_random();
        int idx, lat, rc, erc, bad;
        bit eerr;
        logic [31:0] a, drd, rrd, exp_rd;
        logic rerr;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {24'h40_0000, 8'($urandom)};
                2:       a = {4'h2, 28'($urandom)};
                default: a = $urandom;
            endcase
            lat = $urandom_range(0, 9);
            if (lat == 9) lat = -1;
            drd = $urandom;
            idx = model_decode(a);
            model_txn(a, idx, lat, erc, eerr);
            exp_rd = eerr ? ERRD : drd;
            do_txn(a, idx, lat, drd, rc, rrd, rerr);
            checks++; if (rc != erc) begin failures++; $display("FAIL rand_latency addr=%h: got %0d want %0d", a, rc, erc); end
            checks++; if (rrd !== exp_rd) begin failures++; $display("FAIL rand_rdata addr=%h: got %h want %h", a, rrd, exp_rd); end
            checks++; if (rerr !== logic'(eerr)) begin failures++; $display("FAIL rand_bus_error addr=%h: got %b want %b", a, rerr, eerr); end
            bad = -1;
            if (vlog.size() != erc) bad = 0;
            else foreach (vlog[k]) if (bad < 0 && vlog[k] !== model_valid(idx, erc, eerr, k + 1)) bad = k + 1;
            checks++; if (bad >= 0) begin failures++; $display("FAIL rand_dev_valid addr=%h: trace wrong at cycle %0d (len got %0d want %0d)", a, bad, vlog.size(), erc); end
            checks++; if (err_count !== m_err_count) begin failures++; $display("FAIL rand_err_count: got %h want %h", err_count, m_err_count); end
            checks++; if (err_addr !== m_err_addr) begin failures++; $display("FAIL rand_err_addr: got %h want %h", err_addr, m_err_addr); end
            checks++; if (err_timeout !== m_err_timeout) begin failures++; $display("FAIL rand_err_timeout: got %b want %b", err_timeout, m_err_timeout); end
        end
    endtask

    // Preloading the counter near its ceiling avoids ~65k real error responses.
    task automatic test_saturation();
        int rc, erc; bit eerr; logic [31:0] rrd, a; logic rerr;
        @(negedge clk);
        force dut.err_count = 16'hFFFC;
        @(negedge clk);
        release dut.err_count;
        m_err_count = 16'hFFFC;
        for (int t = 0; t < 6; t++) begin
            a = {4'h8, 28'($urandom)};
            model_txn(a, -1, 0, erc, eerr);
            do_txn(a, -1, 0, 32'h0, rc, rrd, rerr);
            checks++; if (err_count !== m_err_count) begin failures++; $display("FAIL sat_err_count step %0d: got %h want %h", t, err_count, m_err_count); end
        end
        checks++; if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat_final: got %h want ffff", err_count); end
    endtask

    task automatic test_reset_mid_busy();
        int rc; logic [31:0] rrd; logic rerr; logic [31:0] drd;
        @(negedge clk);
        cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h2000_0010; dev_mem_ready = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (dev_mem_valid !== 4'b0100) begin failures++; $display("FAIL rstmid_busy_valid: got %b want 0100", dev_mem_valid); end
        nrst = 1'b0;
        #1;
        checks++; if (dev_mem_valid !== '0) begin failures++; $display("FAIL rstmid_dev_valid: got %b want 0", dev_mem_valid); end
        checks++; if (cpu_mem_ready !== 1'b0 || cpu_mem_rdata !== 32'h0 || bus_error !== 1'b0) begin failures++; $display("FAIL rstmid_cpu_side: got rdy %b data %h err %b want 0 0 0", cpu_mem_ready, cpu_mem_rdata, bus_error); end
        checks++; if (err_count !== 16'h0 || err_addr !== 32'h0 || err_timeout !== 1'b0) begin failures++; $display("FAIL rstmid_status: got %h %h %b want 0 0 0", err_count, err_addr, err_timeout); end
        cpu_mem_valid = 1'b0;
        m_err_count = '0; m_err_addr = '0; m_err_timeout = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        drd = $urandom;
        do_txn(32'h0000_0200, 0, 0, drd, rc, rrd, rerr);
        checks++; if (rc != 1 || rrd !== drd || rerr !== 1'b0) begin failures++; $display("FAIL rstmid_post_access: got cycle %0d data %h err %b want 1 %h 0", rc, rrd, rerr, drd); end
        checks++; if (vlog[0] !== 4'b0001) begin failures++; $display("FAIL rstmid_post_valid: got %b want 0001", vlog[0]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_bram_read();
        test_unmapped();
        test_timeout();
        test_ready_at_expiry();
        test_overlap_back_to_back();
        test_abort();
        test_random();
        test_saturation();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
